serial_vartheta_inv: RTL

Sequential inverse of the SWAN128 half-block linear layer vartheta, used on the decryption datapath. It accepts one 64-bit half-block through a valid/ready handshake and undoes the per-column right rotations by rotating each 16-bit column left. One column is processed per clock through a single shared rotator. The result is held under a valid/ready output handshake until the downstream stage consumes it.

---
 rtl/serial_vartheta_inv_if.sv | 40 ++++
 rtl/serial_vartheta_inv.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/serial_vartheta_inv_if.sv
// -----------------------------------------------------------------------------
// serial_vartheta_inv_if
//   Handshake bundle for the serial inverse-vartheta unit.
//   Input side : in_valid / in_ready / x   (x is one 64-bit half-block, bit 0 = MSB)
//   Output side: out_valid / out_ready / y (y is the registered result)
//   Status     : busy (unit is not idle)
//   Modports   : master = the block driving x and consuming y
//                slave  = the serial_vartheta_inv unit itself
// -----------------------------------------------------------------------------
interface serial_vartheta_inv_if #(
  parameter int SIDE_SIZE = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [0:SIDE_SIZE-1] x;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:SIDE_SIZE-1] y;
  logic                 busy;

  modport master (
    output in_valid,
    output x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y,
    output busy
  );
endinterface

// File: rtl/serial_vartheta_inv.sv
// -----------------------------------------------------------------------------
// serial_vartheta_inv
//   Inverse of the SWAN128 half-block linear layer vartheta, one 16-bit column
//   per clock through a single shared constant-amount rotator.
//     y col0 = rotl(x col0, PC)
//     y col1 = rotl(x col1, PB)
//     y col2 = rotl(x col2, PA)
//     y col3 = x col3
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - serial_vartheta_inv_if.slave (in_valid/in_ready/x,
//            out_valid/out_ready/y, busy)
//   Timing: accept on E0, columns on E1..E4, out_valid after E4, result held
//   until out_ready; next accept no earlier than the edge after consumption.
// -----------------------------------------------------------------------------
module serial_vartheta_inv #(
  parameter int BLOCK_SIZE  = 128,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int COLUMN_SIZE = SIDE_SIZE / 4,
  parameter int PA          = 1,
  parameter int PB          = 3,
  parameter int PC          = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_vartheta_inv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  // Internal vectors are MSB-first descending; bit SIDE_SIZE-1 is x[0].
  logic [SIDE_SIZE-1:0] src_q, src_d;
  logic [SIDE_SIZE-1:0] res_q, res_d;

  logic [COLUMN_SIZE-1:0] head_col;
  logic [COLUMN_SIZE-1:0] rot_col;
  logic [COLUMN_SIZE-1:0] rot_cand [4];
  logic                   accept;

  // Column at the head of the source register is always column cnt.
  assign head_col = src_q[SIDE_SIZE-1 -: COLUMN_SIZE];

  // One constant left-rotation per column slot; cnt picks the slot.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      localparam int AMT = (gi == 0) ? PC :
                           (gi == 1) ? PB :
                           (gi == 2) ? PA : 0;
      if (AMT == 0) begin : g_pass
        assign rot_cand[gi] = head_col;
      end else begin : g_rotl
        assign rot_cand[gi] = {head_col[COLUMN_SIZE-1-AMT:0],
                               head_col[COLUMN_SIZE-1 -: AMT]};
      end
    end
  endgenerate

  assign rot_col = rot_cand[cnt_q];
  assign accept  = bus.in_valid && (state_q == IDLE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          src_d   = bus.x;
          cnt_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Rotated column enters from the LSB side, so after four shifts
        // column 0 sits at the top of the result register.
        res_d = {res_q[SIDE_SIZE-COLUMN_SIZE-1:0], rot_col};
        src_d = {src_q[SIDE_SIZE-COLUMN_SIZE-1:0], {COLUMN_SIZE{1'b0}}};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      RUN: begin
      end
      DONE: begin
        bus.out_valid = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.y = res_q;

endmodule
